io_spi_master: RTL and testbench

Memory-mapped SPI master that responds to the J1 IO bus (io_rd/io_wr/io_dout) and drives the board's SPI flash pins (SCK, MOSI, MISO, CS).
It replaces firmware bit-banging of the flash PIOS bits with a byte-wide hardware shifter.
Address decode stays in the top level, which presents two select strobes; read data is zero when unselected, so the top ORs it into io_din.
SPI mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transfer.

---
 rtl/io_spi_master_pkg.sv | 17 +
 rtl/io_spi_shifter.sv | 110 +++++++++++
 rtl/io_spi_master.sv | 111 +++++++++++
 tb/tb_io_spi_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_spi_master_pkg.sv
// Shared types and register bit positions for the io_spi_master block.
// The top level maps these onto the J1 IO bus.
package io_spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } spi_state_e;

    localparam int unsigned CTRL_CS    = 0;
    localparam int unsigned STAT_READY = 0;
    localparam int unsigned STAT_RXV   = 1;
    localparam int unsigned STAT_OVR   = 2;
    localparam int unsigned STAT_CS    = 3;

endpackage

// File: rtl/io_spi_shifter.sv
// Mode-0 SPI byte engine: half-period divider, SCK phase FSM and an 8-bit shift register.
// MISO is sampled on each SCK rise; MOSI changes on each SCK fall.
module io_spi_shifter
    import io_spi_master_pkg::*;
#(
    parameter int unsigned HALF  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi
);

    localparam logic [CNT_W-1:0] DivLast = CNT_W'(HALF - 1);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start) begin
                    shift_d = tx_byte;
                    mosi_d  = tx_byte[7];
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    shift_d = {shift_q[6:0], miso};
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        done    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // The shift above already moved the next tx bit into the MSB.
                        mosi_d  = shift_q[7];
                        bit_d   = bit_q + 3'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
                bit_d   = '0;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign rx_byte = shift_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/io_spi_master.sv
// Memory-mapped SPI master for the J1 IO bus: data and ctrl/status registers around
// a byte shifter. rd_data is zero when unselected so the top level can OR it into io_din.
module io_spi_master
    import io_spi_master_pkg::*;
#(
    parameter int unsigned HALF  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic        sel_data,
    input  logic        sel_ctrl,
    input  logic [15:0] io_dout,
    output logic [15:0] rd_data,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        busy
);

    logic       wr_data, wr_ctrl, rd_dat, rd_ctl;
    logic       start, done;
    logic [7:0] shift_rx;
    logic       cs_en_q, cs_en_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic [3:0] status;

    assign wr_data = io_wr & sel_data;
    assign wr_ctrl = io_wr & sel_ctrl;
    assign rd_dat  = io_rd & sel_data;
    assign rd_ctl  = io_rd & sel_ctrl;
    assign start   = wr_data & ~busy;

    io_spi_shifter #(
        .HALF  (HALF),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk     (clk),
        .resetq  (resetq),
        .start   (start),
        .tx_byte (io_dout[7:0]),
        .miso    (spi_miso),
        .busy    (busy),
        .done    (done),
        .rx_byte (shift_rx),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

    always_ff @(posedge clk) begin
        if (!resetq) begin
            cs_en_q    <= 1'b0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cs_en_q    <= cs_en_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Flag clears come first so a coincident set wins.
    always_comb begin
        cs_en_d    = cs_en_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (wr_ctrl && !busy) begin
            cs_en_d = io_dout[CTRL_CS];
        end
        if (rd_dat) begin
            rx_valid_d = 1'b0;
        end
        if (done) begin
            rx_byte_d  = shift_rx;
            rx_valid_d = 1'b1;
        end
        if (rd_ctl) begin
            overrun_d = 1'b0;
        end
        if ((wr_data || wr_ctrl) && busy) begin
            overrun_d = 1'b1;
        end
    end

    always_comb begin
        status             = '0;
        status[STAT_READY] = ~busy;
        status[STAT_RXV]   = rx_valid_q;
        status[STAT_OVR]   = overrun_q;
        status[STAT_CS]    = cs_en_q;
        rd_data            = '0;
        if (sel_data) begin
            rd_data = rd_data | {8'd0, rx_byte_q};
        end
        if (sel_ctrl) begin
            rd_data = rd_data | {12'd0, status};
        end
    end

    assign spi_cs_n = ~cs_en_q;

endmodule

// File: tb/tb_io_spi_master.sv
// Directed bench for io_spi_master: one HALF=2 instance with a scripted slave and one
// HALF=1 instance whose MISO is MOSI delayed by one clock (as the top-level input register).
module tb_io_spi_master;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic        sel_data = 1'b0;
    logic        sel_ctrl = 1'b0;
    logic [15:0] io_dout = 16'd0;

    logic [15:0] rd_data2, rd_data1;
    logic        sck2, mosi2, miso2, cs_n2, busy2;
    logic        sck1, mosi1, miso1, cs_n1, busy1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    io_spi_master #(.HALF(2), .CNT_W(8)) u_dut2 (
        .clk      (clk),
        .resetq   (resetq),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .sel_data (sel_data),
        .sel_ctrl (sel_ctrl),
        .io_dout  (io_dout),
        .rd_data  (rd_data2),
        .spi_sck  (sck2),
        .spi_mosi (mosi2),
        .spi_miso (miso2),
        .spi_cs_n (cs_n2),
        .busy     (busy2)
    );

    io_spi_master #(.HALF(1), .CNT_W(8)) u_dut1 (
        .clk      (clk),
        .resetq   (resetq),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .sel_data (sel_data),
        .sel_ctrl (sel_ctrl),
        .io_dout  (io_dout),
        .rd_data  (rd_data1),
        .spi_sck  (sck1),
        .spi_mosi (mosi1),
        .spi_miso (miso1),
        .spi_cs_n (cs_n1),
        .busy     (busy1)
    );

    // Records MOSI at every SCK rise of the HALF=2 instance.
    logic       sck2_prev = 1'b0;
    logic [7:0] mon_bits = 8'd0;
    int         mon_rises = 0;
    always @(negedge clk) begin
        if (sck2 && !sck2_prev) begin
            mon_bits  <= {mon_bits[6:0], mosi2};
            mon_rises <= mon_rises + 1;
        end
        sck2_prev <= sck2;
    end

    // Slave presents slave_byte MSB first, one bit per rising edge seen.
    logic [7:0] slave_byte = 8'd0;
    int         rise_base = 0;
    int         slv_idx;
    assign slv_idx = mon_rises - rise_base;
    assign miso2 = (slv_idx >= 0 && slv_idx < 8) ? slave_byte[3'(7 - slv_idx)] : 1'b0;

    logic lb_q = 1'b0;
    always @(posedge clk) lb_q <= mosi1;
    assign miso1 = lb_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic is_data, input logic [15:0] d);
        sel_data = is_data;
        sel_ctrl = !is_data;
        io_dout  = d;
        io_wr    = 1'b1;
        tick();
        io_wr    = 1'b0;
        sel_data = 1'b0;
        sel_ctrl = 1'b0;
    endtask

    task automatic bus_rd(input logic is_data, output logic [15:0] v2, output logic [15:0] v1);
        sel_data = is_data;
        sel_ctrl = !is_data;
        io_rd    = 1'b1;
        #1;
        v2 = rd_data2;
        v1 = rd_data1;
        tick();
        io_rd    = 1'b0;
        sel_data = 1'b0;
        sel_ctrl = 1'b0;
    endtask

    // Upper byte of the data write is junk on purpose; it must be ignored.
    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] slave);
        slave_byte = slave;
        rise_base  = mon_rises;
        bus_wr(1'b1, {8'hC3, tx});
    endtask

    task automatic wait_idle2(output int cyc);
        cyc = 0;
        while (busy2 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [15:0] v2, v1;
        logic [7:0]  tx;
        int          c;

        @(negedge clk);
        tick();
        tick();
        resetq = 1'b1;
        tick();

        // Reset and idle read
        chk("rst_busy", 16'(busy2), 16'd0);
        chk("rst_cs_n", 16'(cs_n2), 16'd1);
        chk("rst_sck", 16'(sck2), 16'd0);
        chk("rst_mosi", 16'(mosi2), 16'd0);
        #1;
        chk("rst_nosel", rd_data2, 16'h0000);
        bus_rd(1'b0, v2, v1);
        chk("rst_ctrl", v2, 16'h0001);
        bus_rd(1'b1, v2, v1);
        chk("rst_data", v2, 16'h0000);

        // Basic byte A5 out, 3C in
        bus_wr(1'b0, 16'h0001);
        chk("cs_low", 16'(cs_n2), 16'd0);
        start_xfer(8'hA5, 8'h3C);
        chk("start_busy", 16'(busy2), 16'd1);
        chk("start_mosi", 16'(mosi2), 16'd1);
        wait_idle2(c);
        chk("basic_busy_cycles", 16'(c), 16'd32);
        chk("basic_mosi", 16'(mon_bits), 16'h00A5);
        chk("basic_rises", 16'(mon_rises - rise_base), 16'd8);
        bus_rd(1'b0, v2, v1);
        chk("basic_ctrl", v2, 16'h000B);
        bus_rd(1'b1, v2, v1);
        chk("basic_data", v2, 16'h003C);
        bus_rd(1'b0, v2, v1);
        chk("basic_rxv_clr", v2, 16'h0009);

        // Overrun: data and ctrl writes while busy are dropped
        start_xfer(8'h55, 8'h00);
        repeat (4) tick();
        bus_wr(1'b1, 16'h00FF);
        bus_wr(1'b0, 16'h0000);
        chk("ovr_cs_held", 16'(cs_n2), 16'd0);
        wait_idle2(c);
        chk("ovr_busy_cycles", 16'(c), 16'd26);
        repeat (4) tick();
        chk("ovr_no_restart", 16'(busy2), 16'd0);
        chk("ovr_mosi", 16'(mon_bits), 16'h0055);
        chk("ovr_rises", 16'(mon_rises - rise_base), 16'd8);
        bus_rd(1'b0, v2, v1);
        chk("ovr_ctrl", v2, 16'h000F);
        bus_rd(1'b0, v2, v1);
        chk("ovr_clr", v2, 16'h000B);
        bus_rd(1'b1, v2, v1);
        chk("ovr_data", v2, 16'h0000);

        // Write in the completion cycle is dropped; the next cycle starts a transfer
        start_xfer(8'h12, 8'h5A);
        repeat (31) tick();
        chk("edge_busy_last", 16'(busy2), 16'd1);
        bus_wr(1'b1, 16'h0034);
        chk("edge_busy_fell", 16'(busy2), 16'd0);
        start_xfer(8'h56, 8'hA6);
        chk("edge_busy_rose", 16'(busy2), 16'd1);
        // Read data in this transfer's completion cycle: rx_valid set must win.
        repeat (31) tick();
        bus_rd(1'b1, v2, v1);
        chk("edge_old_data", v2, 16'h005A);
        chk("edge_done", 16'(busy2), 16'd0);
        chk("edge_mosi", 16'(mon_bits), 16'h0056);
        bus_rd(1'b0, v2, v1);
        chk("edge_ctrl", v2, 16'h000F);
        bus_rd(1'b0, v2, v1);
        chk("edge_ctrl2", v2, 16'h000B);
        bus_rd(1'b1, v2, v1);
        chk("edge_new_data", v2, 16'h00A6);

        // Reset mid-transfer (bit 3), then a clean 81 transfer
        start_xfer(8'hF0, 8'h00);
        repeat (14) tick();
        resetq = 1'b0;
        tick();
        resetq = 1'b1;
        chk("mid_rst_busy", 16'(busy2), 16'd0);
        chk("mid_rst_sck", 16'(sck2), 16'd0);
        chk("mid_rst_cs_n", 16'(cs_n2), 16'd1);
        bus_rd(1'b0, v2, v1);
        chk("mid_rst_ctrl", v2, 16'h0001);
        bus_wr(1'b0, 16'h0001);
        start_xfer(8'h81, 8'h7E);
        tick();
        chk("rise_t1", 16'(sck2), 16'd0);
        tick();
        chk("rise_t2", 16'(sck2), 16'd1);
        wait_idle2(c);
        chk("post_rst_cycles", 16'(c + 2), 16'd32);
        chk("post_rst_mosi", 16'(mon_bits), 16'h0081);
        bus_rd(1'b1, v2, v1);
        chk("post_rst_data", v2, 16'h007E);

        // HALF=1 sweep: loopback delayed one clock returns tx shifted right by one
        for (int i = 0; i < 256; i++) begin
            tx = 8'($urandom_range(0, 255));
            bus_wr(1'b1, {8'h00, tx});
            c = 0;
            while (busy1 && c < 50) begin
                tick();
                c++;
            end
            chk("h1_cycles", 16'(c), 16'd16);
            bus_rd(1'b1, v2, v1);
            chk("h1_rx", v1, {8'd0, 1'b0, tx[7:1]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
